sseg_bcd_display: RTL and testbench

// - Downstream of the RAT MCU output port. Consumes an 8-bit output value and drives the 4-digit multiplexed 7-seg display on the Basys3 (ANODES/CATHODES).
// - Converts the value to 3 decimal digits with a sequential double-dabble engine, 1 shift per cycle.
// - Time-multiplexes the digits with a refresh divider.

---
 rtl/sseg_bcd_display.sv | 193 +++++++++++++++++++
 tb/tb_sseg_bcd_display.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sseg_bcd_display.sv
// -----------------------------------------------------------------------------
// sseg_bcd_display
//
// Takes the 8-bit value written to the MCU output port and shows it in decimal
// on the Basys3 4-digit multiplexed seven-segment display. A sequential
// double-dabble engine does one shift per clock. The result is committed to
// the displayed digits in one step, so the display never shows a partial value.
//
// Parameters
//   REFRESH_DIV : clock cycles per digit slot (>= 2). 100000 @ 100 MHz = 1 kHz/digit.
//
// Ports
//   CLK      in   1  system clock, rising edge
//   RST_N    in   1  asynchronous active-low reset
//   DATA     in   8  unsigned value, sampled only on an accepted LOAD
//   LOAD     in   1  one-cycle strobe; ignored while BUSY is high
//   BUSY     out  1  conversion in progress (9 cycles per accepted LOAD)
//   ANODES   out  4  active-low digit enables, [0] = rightmost digit
//   CATHODES out  8  {DP,G,F,E,D,C,B,A}, active-low
//
// Build option
//   SSEG_LZB_EN : when defined, leading zeros are blanked (hundreds when zero,
//                 tens when hundreds and tens are zero). Ones is always shown.
// -----------------------------------------------------------------------------
module sseg_bcd_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DATA,
    input  logic       LOAD,
    output logic       BUSY,
    output logic [3:0] ANODES,
    output logic [7:0] CATHODES
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             load_acc;
    logic [7:0]       bin;
    logic [11:0]      bcd;
    logic [11:0]      bcd_adj;
    logic [19:0]      shifted;
    logic [2:0]       bit_cnt;
    logic [3:0]       dig_h, dig_t, dig_o;
    logic [3:0]       src_h, src_t, src_o;
    logic             blank_h, blank_t;
    logic [CNT_W-1:0] ref_cnt;
    logic [1:0]       idx;
    logic [7:0]       seg_nxt;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] v);
        logic [11:0] r;
        for (int n = 0; n < 3; n++) begin
            r[n*4 +: 4] = (v[n*4 +: 4] >= 4'd5) ? v[n*4 +: 4] + 4'd3 : v[n*4 +: 4];
        end
        return r;
    endfunction

    // Digit to active-low segment pattern; codes above 9 and blanked digits are dark.
    function automatic logic [7:0] seg7(input logic [3:0] d, input logic blank);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return blank ? 8'hFF : s;
    endfunction

    // ---- conversion control ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_acc  = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD) begin
                    load_acc  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == 3'd0) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY = (state != IDLE);

    // ---- double-dabble datapath ----
    assign bcd_adj = dd_adjust(bcd);
    assign shifted = {bcd_adj, bin} << 1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            dig_h   <= '0;
            dig_t   <= '0;
            dig_o   <= '0;
        end else begin
            if (load_acc) begin
                bin     <= DATA;
                bcd     <= '0;
                bit_cnt <= 3'd7;
            end else if (state == SHIFT) begin
                bcd     <= shifted[19:8];
                bin     <= shifted[7:0];
                bit_cnt <= bit_cnt - 3'd1;
            end
            if (state == COMMIT) begin
                dig_h <= bcd[11:8];
                dig_t <= bcd[7:4];
                dig_o <= bcd[3:0];
            end
        end
    end

    // ---- refresh and segment output ----
    // During COMMIT the new digits are forwarded so the display switches on the
    // same edge that the committed digits update.
    assign src_h = (state == COMMIT) ? bcd[11:8] : dig_h;
    assign src_t = (state == COMMIT) ? bcd[7:4]  : dig_t;
    assign src_o = (state == COMMIT) ? bcd[3:0]  : dig_o;

`ifdef SSEG_LZB_EN
    assign blank_h = (src_h == 4'd0);
    assign blank_t = (src_h == 4'd0) && (src_t == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    always_comb begin
        seg_nxt = 8'hFF;
        case (idx)
            2'd0:    seg_nxt = seg7(src_o, 1'b0);
            2'd1:    seg_nxt = seg7(src_t, blank_t);
            2'd2:    seg_nxt = seg7(src_h, blank_h);
            default: seg_nxt = 8'hFF;
        endcase
    end

    // Anode and cathode register from the same idx on the same edge, so a
    // digit can never appear on the wrong anode.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ref_cnt  <= '0;
            idx      <= '0;
            ANODES   <= 4'b1111;
            CATHODES <= 8'hFF;
        end else begin
            if (ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            ANODES   <= ~(4'b0001 << idx);
            CATHODES <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_sseg_bcd_display.sv
module tb_sseg_bcd_display;

    logic       CLK;
    logic       RST_N;
    logic [7:0] DATA;
    logic       LOAD;
    logic       BUSY;
    logic [3:0] ANODES;
    logic [7:0] CATHODES;

    int n_tests;
    int n_fail;

    sseg_bcd_display #(.REFRESH_DIV(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .DATA     (DATA),
        .LOAD     (LOAD),
        .BUSY     (BUSY),
        .ANODES   (ANODES),
        .CATHODES (CATHODES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic do_load(input logic [7:0] d);
        DATA = d;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 30; k++) begin
            if (BUSY === 1'b0) break;
            @(negedge CLK);
        end
        if (k == 30) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic get_seg(input int idx, output logic [7:0] c);
        logic [3:0] pat;
        int k;
        pat = ~(4'b0001 << idx);
        c = 8'h00;
        for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (ANODES === pat) begin
                c = CATHODES;
                break;
            end
        end
        if (k == 40) check("anode_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_display(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] c;
        get_seg(0, c); check({tag, "_idx0"}, {24'd0, c}, {24'd0, e0});
        get_seg(1, c); check({tag, "_idx1"}, {24'd0, c}, {24'd0, e1});
        get_seg(2, c); check({tag, "_idx2"}, {24'd0, c}, {24'd0, e2});
        get_seg(3, c); check({tag, "_idx3"}, {24'd0, c}, {24'd0, e3});
    endtask

    initial begin
        logic [7:0] z1, z2;
        int cnt;
        n_tests = 0;
        n_fail  = 0;
        LOAD  = 1'b0;
        DATA  = 8'd0;
        RST_N = 1'b1;
`ifdef SSEG_LZB_EN
        z1 = 8'hFF; z2 = 8'hFF;
`else
        z1 = 8'hC0; z2 = 8'hC0;
`endif

        // Reset held for 3 cycles
        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_anodes", {28'd0, ANODES}, 32'hF);
        check("rst_cathodes", {24'd0, CATHODES}, 32'hFF);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        RST_N = 1'b1;

        // Anode rotation: 4 clocks per slot starting at 1110
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            check($sformatf("anode_seq%0d", i), {28'd0, ANODES},
                  {28'd0, ~(4'b0001 << ((i / 4) % 4))});
        end
        check_display("rst_disp", 8'hC0, z1, z2, 8'hFF);

        // 255 -> 2,5,5 and BUSY for exactly 9 cycles
        check("busy_before", {31'd0, BUSY}, 32'd0);
        do_load(8'd255);
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge CLK);
        end
        check("busy_len", cnt, 32'd9);
        check_display("d255", 8'h92, 8'h92, 8'hA4, 8'hFF);

        // 42 then 99 three cycles later while busy: 99 dropped
        do_load(8'd42);
        @(negedge CLK);
        @(negedge CLK);
        check("busy_mid", {31'd0, BUSY}, 32'd1);
        do_load(8'd99);
        wait_idle();
        check_display("d42", 8'hA4, 8'h99, z2, 8'hFF);

        // 100 with DATA changed right after acceptance
        do_load(8'd100);
        DATA = 8'd0;
        wait_idle();
        check_display("d100", 8'hC0, 8'hC0, 8'hF9, 8'hFF);

        // 200 aborted by reset in the 4th shift cycle
        do_load(8'd200);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("abort_anodes", {28'd0, ANODES}, 32'hF);
        check("abort_cathodes", {24'd0, CATHODES}, 32'hFF);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post_abort_busy", {31'd0, BUSY}, 32'd0);
        check_display("abort_disp", 8'hC0, z1, z2, 8'hFF);

        // Back-to-back: 9, then 10 on first idle cycle
        do_load(8'd9);
        wait_idle();
        do_load(8'd10);
        check("b2b_busy", {31'd0, BUSY}, 32'd1);
        wait_idle();
        check_display("d10", 8'hC0, 8'hF9, z2, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
